// File: rtl/mips_run_monitor_if.sv
// CPU-side bus seen by the run monitor: fetch PC, data-memory write port
// and the reset the monitor drives back into the CPU.
interface mips_run_monitor_if #(
  parameter int DW = 32
);
  logic [DW-1:0] pc_current;
  logic          we_dm;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] wd_dm;
  logic          cpu_rst;

  modport master (output pc_current, we_dm, alu_out, wd_dm, input cpu_rst);
  modport slave  (input pc_current, we_dm, alu_out, wd_dm, output cpu_rst);
endinterface

// File: rtl/mips_run_monitor.sv
// Run monitor for a MIPS core: resets the CPU, lets it run until a halt PC,
// a checked store or a cycle timeout, and reports the verdict and counters.
module mips_run_monitor #(
  parameter int            DW         = 32,
  parameter int            CNT_W      = 32,
  parameter int            RST_CYCLES = 2,
  parameter longint        TIMEOUT    = 1000,
  parameter logic [DW-1:0] HALT_PC    = 32'h48,
  parameter logic [DW-1:0] CHK_ADDR   = 32'h54,
  parameter logic [DW-1:0] CHK_DATA   = 32'h7
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_run_monitor_if.slave    cpu,
  input  logic                 start,
  input  logic [1:0]           halt_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     store_cnt,
  output logic [DW-1:0]        halt_pc
);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 64'd1);
  localparam logic [7:0]       RST_LOAD = 8'(RST_CYCLES);

  state_t           state_r, state_next;
  logic [7:0]       rst_cnt_r;
  logic [1:0]       mode_r;
  logic             cpu_rst_r, busy_r, done_r, pass_r, timeout_r;
  logic [CNT_W-1:0] cycle_cnt_r, store_cnt_r;
  logic [DW-1:0]    halt_pc_r;
  logic             pc_hit_s, st_hit_s, q_pc_s, q_st_s, hit_s, tmo_s;

  // Mode 2'b11 decodes like 2'b10: only 2'b00 masks stores, only 2'b01 masks PC.
  always_comb begin
    pc_hit_s = (cpu.pc_current == HALT_PC);
    st_hit_s = cpu.we_dm && (cpu.alu_out == CHK_ADDR);
    q_pc_s   = pc_hit_s && (mode_r != 2'b01);
    q_st_s   = st_hit_s && (mode_r != 2'b00);
    hit_s    = q_pc_s || q_st_s;
    tmo_s    = (cycle_cnt_r == TMO_LAST);
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_next = RESET;
        else       state_next = state_r;
      end
      RESET: begin
        if (rst_cnt_r <= 8'd1) state_next = RUN;
        else                   state_next = RESET;
      end
      RUN: begin
        if (hit_s || tmo_s) state_next = DONE;
        else                state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next;
  end

  // Status flags are registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
      cycle_cnt_r <= '0;
      store_cnt_r <= '0;
      halt_pc_r   <= '0;
      mode_r      <= 2'b00;
      rst_cnt_r   <= 8'd0;
    end else begin
      cpu_rst_r <= (state_next != RUN);
      busy_r    <= (state_next == RESET) || (state_next == RUN);
      done_r    <= (state_next == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            cycle_cnt_r <= '0;
            store_cnt_r <= '0;
            halt_pc_r   <= '0;
            mode_r      <= halt_mode;
            rst_cnt_r   <= RST_LOAD;
          end
        end
        RESET: rst_cnt_r <= rst_cnt_r - 8'd1;
        RUN: begin
          cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
          if (cpu.we_dm) store_cnt_r <= store_cnt_r + CNT_W'(1);
          // A store hit carries the data verdict even when the PC also hits.
          if (q_st_s) begin
            pass_r    <= (cpu.wd_dm == CHK_DATA);
            halt_pc_r <= cpu.pc_current;
          end else if (q_pc_s) begin
            pass_r    <= 1'b1;
            halt_pc_r <= cpu.pc_current;
          end else if (tmo_s) begin
            pass_r    <= 1'b0;
            timeout_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu.cpu_rst = cpu_rst_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign timeout     = timeout_r;
  assign cycle_cnt   = cycle_cnt_r;
  assign store_cnt   = store_cnt_r;
  assign halt_pc     = halt_pc_r;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench: two monitors (TIMEOUT=1000 and TIMEOUT=16) watch a simple
// CPU model whose PC steps by 4 and whose stores follow a small schedule.
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  halt_mode = 2'b00;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        cur_b = 1'b0;
  logic [31:0] pc_base = 32'h100;
  int          chk_cycle = 0;
  logic [31:0] chk_data = 32'h0;
  logic        others = 1'b0;

  logic [31:0] pc_m;
  int          rk;
  logic        m_rst, m_we;
  logic [31:0] m_alu, m_wd;

  logic        a_busy, a_done, a_pass, a_tmo, b_busy, b_done, b_pass, b_tmo;
  logic [31:0] a_cc, a_sc, a_hpc, b_cc, b_sc, b_hpc;
  logic        s_cpu_rst, s_busy, s_done, s_pass, s_tmo;
  logic [31:0] s_cc, s_sc, s_hpc;

  always #5 clk = ~clk;

  mips_run_monitor_if #(.DW(32)) ia ();
  mips_run_monitor_if #(.DW(32)) ib ();

  assign ia.pc_current = pc_m;
  assign ia.we_dm      = m_we;
  assign ia.alu_out    = m_alu;
  assign ia.wd_dm      = m_wd;
  assign ib.pc_current = pc_m;
  assign ib.we_dm      = m_we;
  assign ib.alu_out    = m_alu;
  assign ib.wd_dm      = m_wd;

  mips_run_monitor dut_a (
    .clk(clk), .rst(rst), .cpu(ia), .start(start), .halt_mode(halt_mode),
    .busy(a_busy), .done(a_done), .pass(a_pass), .timeout(a_tmo),
    .cycle_cnt(a_cc), .store_cnt(a_sc), .halt_pc(a_hpc)
  );

  mips_run_monitor #(.TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .cpu(ib), .start(start), .halt_mode(halt_mode),
    .busy(b_busy), .done(b_done), .pass(b_pass), .timeout(b_tmo),
    .cycle_cnt(b_cc), .store_cnt(b_sc), .halt_pc(b_hpc)
  );

  assign m_rst     = cur_b ? ib.cpu_rst : ia.cpu_rst;
  assign s_cpu_rst = m_rst;
  assign s_busy    = cur_b ? b_busy : a_busy;
  assign s_done    = cur_b ? b_done : a_done;
  assign s_pass    = cur_b ? b_pass : a_pass;
  assign s_tmo     = cur_b ? b_tmo  : a_tmo;
  assign s_cc      = cur_b ? b_cc   : a_cc;
  assign s_sc      = cur_b ? b_sc   : a_sc;
  assign s_hpc     = cur_b ? b_hpc  : a_hpc;

  // CPU model: RUN cycle k (1-based) fetches pc_base + 4*(k-1).
  always @(posedge clk) begin
    if (m_rst) begin
      pc_m <= pc_base;
      rk   <= 1;
    end else begin
      pc_m <= pc_m + 32'd4;
      rk   <= rk + 1;
    end
  end

  always_comb begin
    m_we  = 1'b0;
    m_alu = 32'h100;
    m_wd  = 32'h1;
    if (m_rst !== 1'b1) begin
      m_we = (rk == chk_cycle) ||
             (others && (rk == 5 || rk == 10 || rk == 15 || rk == 20));
      if (rk == chk_cycle) begin
        m_alu = 32'h54;
        m_wd  = chk_data;
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] base;
    int          chk;
    logic [31:0] data;
    logic        oth;
    logic        use_b;
    logic        e_pass;
    logic        e_tmo;
    int          e_cc;
    int          e_sc;
    logic [31:0] e_hpc;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (s_done !== 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk({name, "_done"}, {31'd0, s_done}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    n;
    string nm;
    nm        = $sformatf("vec%0d", idx);
    cur_b     = v.use_b;
    pc_base   = v.base;
    chk_cycle = v.chk;
    chk_data  = v.data;
    others    = v.oth;
    rst = 1'b1;
    step();
    rst = 1'b0;
    halt_mode = v.mode;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, "_busy"}, {31'd0, s_busy}, 32'd1);
    n = 0;
    while (s_cpu_rst === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk({nm, "_rst_len"}, 32'(n), 32'd2);
    wait_done(nm);
    chk({nm, "_pass"},    {31'd0, s_pass}, {31'd0, v.e_pass});
    chk({nm, "_timeout"}, {31'd0, s_tmo},  {31'd0, v.e_tmo});
    chk({nm, "_cycles"},  s_cc,  32'(v.e_cc));
    chk({nm, "_stores"},  s_sc,  32'(v.e_sc));
    chk({nm, "_halt_pc"}, s_hpc, v.e_hpc);
    chk({nm, "_idle_busy"}, {31'd0, s_busy}, 32'd0);
  endtask

  initial begin
    int n;
    //            mode   base    chk data   oth   B     pass  tmo   cc  sc  halt_pc
    vecs[0] = '{2'b00, 32'h4,   0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 18, 0, 32'h48};
    vecs[1] = '{2'b01, 32'h100, 30, 32'h7, 1'b1, 1'b0, 1'b1, 1'b0, 30, 5, 32'h174};
    vecs[2] = '{2'b01, 32'h100, 30, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0, 30, 5, 32'h174};
    vecs[3] = '{2'b00, 32'h100, 0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 16, 0, 32'h0};
    vecs[4] = '{2'b10, 32'h4,   18, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 18, 1, 32'h48};
    vecs[5] = '{2'b10, 32'hC,   0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 0, 32'h48};
    vecs[6] = '{2'b11, 32'h100, 12, 32'h7, 1'b0, 1'b0, 1'b1, 1'b0, 12, 1, 32'h12C};
    vecs[7] = '{2'b00, 32'h4,   10, 32'h7, 1'b1, 1'b0, 1'b1, 1'b0, 18, 3, 32'h48};
    vecs[8] = '{2'b01, 32'h4,   25, 32'h7, 1'b1, 1'b0, 1'b1, 1'b0, 25, 5, 32'h64};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_cpu_rst", {31'd0, a_busy ? 1'b0 : ia.cpu_rst}, 32'd1);
    chk("rst_busy",    {31'd0, a_busy}, 32'd0);
    chk("rst_done",    {31'd0, a_done}, 32'd0);
    chk("rst_pass",    {31'd0, a_pass}, 32'd0);
    chk("rst_timeout", {31'd0, a_tmo},  32'd0);
    chk("rst_cycles",  a_cc,  32'd0);
    chk("rst_stores",  a_sc,  32'd0);
    chk("rst_halt_pc", a_hpc, 32'd0);

    // rst and start together: rst wins, monitor stays idle.
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_prio_cpu_rst", {31'd0, ia.cpu_rst}, 32'd1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // rst during RUN cycle 5.
    cur_b = 1'b0; pc_base = 32'h100; chk_cycle = 0; others = 1'b1;
    halt_mode = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (ia.cpu_rst === 1'b1 && n < 20) begin n++; step(); end
    for (int i = 0; i < 4; i++) step();
    chk("mid_pre_cycles", a_cc, 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_cpu_rst", {31'd0, ia.cpu_rst}, 32'd1);
    chk("mid_busy",    {31'd0, a_busy}, 32'd0);
    chk("mid_done",    {31'd0, a_done}, 32'd0);
    chk("mid_cycles",  a_cc, 32'd0);
    chk("mid_stores",  a_sc, 32'd0);
    chk("mid_halt_pc", a_hpc, 32'd0);

    // start during RUN is ignored; start in DONE restarts with cleared results.
    pc_base = 32'h4; others = 1'b1;
    halt_mode = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (ia.cpu_rst === 1'b1 && n < 20) begin n++; step(); end
    step();
    step();
    halt_mode = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_start_cpu_rst", {31'd0, ia.cpu_rst}, 32'd0);
    chk("run_start_busy",    {31'd0, a_busy}, 32'd1);
    wait_done("run_start");
    chk("run_start_cycles",  a_cc,  32'd18);
    chk("run_start_stores",  a_sc,  32'd3);
    chk("run_start_pass",    {31'd0, a_pass}, 32'd1);
    chk("run_start_halt_pc", a_hpc, 32'h48);
    step();
    chk("done_hold_cycles", a_cc, 32'd18);
    halt_mode = 2'b00;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_done",    {31'd0, a_done}, 32'd0);
    chk("restart_busy",    {31'd0, a_busy}, 32'd1);
    chk("restart_cpu_rst", {31'd0, ia.cpu_rst}, 32'd1);
    chk("restart_cycles",  a_cc,  32'd0);
    chk("restart_stores",  a_sc,  32'd0);
    chk("restart_pass",    {31'd0, a_pass}, 32'd0);
    chk("restart_halt_pc", a_hpc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
